insmem_loader: RTL

//  Write-side master for INSMEM. Takes a byte stream from the host link (valid/ready), e.g. the UART receiver.

---
 rtl/insmem_pkg.sv | 30 +++
 rtl/insmem_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/insmem_pkg.sv
// Shared constants for the INSMEM loader: sizes, frame layout and the loader state encoding.
package insmem_pkg;

  localparam int DEF_PC_BITS    = 6;
  localparam int DEF_WORD_BITS  = 16;
  localparam int BYTES_PER_WORD = 2;
  localparam int LEN_BYTES      = 2;

  typedef logic [3:0] ld_state_t;

  localparam ld_state_t ST_IDLE    = 4'd0;
  localparam ld_state_t ST_LEN_HI  = 4'd1;
  localparam ld_state_t ST_LEN_LO  = 4'd2;
  localparam ld_state_t ST_DATA_HI = 4'd3;
  localparam ld_state_t ST_DATA_LO = 4'd4;
  localparam ld_state_t ST_WRITE   = 4'd5;
  localparam ld_state_t ST_CSUM    = 4'd6;
  localparam ld_state_t ST_DONE    = 4'd7;
  localparam ld_state_t ST_ERROR   = 4'd8;

  function automatic logic is_rx_state(input ld_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_CSUM);
  endfunction

  function automatic logic is_idle_state(input ld_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/insmem_loader.sv
// Frames a host byte stream (len, words hi-first, xor csum) into INSMEM writes; write pulse one cycle
// after the low-byte transfer; rx_ready drops outside receive states so the host simply stalls.
module insmem_loader
  import insmem_pkg::*;
#(
  parameter int PC_BITS   = DEF_PC_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS
) (
  input  logic                 clka,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 we_insmem,
  output logic [PC_BITS-1:0]   pc,
  output logic [WORD_BITS-1:0] instruction_in,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_error,
  output logic [PC_BITS:0]     words_loaded
);

  localparam logic [16:0] CAPACITY = 17'(1) << PC_BITS;

  ld_state_t          state;
  ld_state_t          state_nxt;
  logic               xfer;
  logic               take_start;
  logic [7:0]         len_hi;
  logic [7:0]         byte_hi;
  logic [7:0]         csum;
  logic [15:0]        count;
  logic [15:0]        len_full;
  logic [15:0]        written_next;
  logic [PC_BITS-1:0] addr;

  assign xfer         = rx_valid && rx_ready;
  assign take_start   = start && is_idle_state(state);
  assign len_full     = {len_hi, rx_data};
  assign written_next = 16'(words_loaded) + 16'd1;

  always_ff @(posedge clka) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_nxt = ST_LEN_HI;
      ST_LEN_HI:  if (xfer) state_nxt = ST_LEN_LO;
      ST_LEN_LO: begin
        if (xfer) begin
          if ({1'b0, len_full} > CAPACITY) state_nxt = ST_ERROR;
          else if (len_full == 16'd0)      state_nxt = ST_CSUM;
          else                             state_nxt = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (xfer) state_nxt = ST_DATA_LO;
      ST_DATA_LO: if (xfer) state_nxt = ST_WRITE;
      ST_WRITE:   state_nxt = (written_next < count) ? ST_DATA_HI : ST_CSUM;
      ST_CSUM:    if (xfer) state_nxt = (rx_data == csum) ? ST_DONE : ST_ERROR;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Reset gates the write strobe combinationally so a reset landing on WRITE suppresses that word.
  always_comb begin
    rx_ready  = is_rx_state(state);
    busy      = !is_idle_state(state);
    we_insmem = (state == ST_WRITE) && !reset;
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      len_hi         <= '0;
      byte_hi        <= '0;
      csum           <= '0;
      count          <= '0;
      addr           <= '0;
      pc             <= '0;
      instruction_in <= '0;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
      words_loaded   <= '0;
    end else begin
      if (take_start) begin
        csum         <= '0;
        count        <= '0;
        addr         <= '0;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
        words_loaded <= '0;
      end
      case (state)
        ST_LEN_HI: if (xfer) len_hi <= rx_data;
        ST_LEN_LO: begin
          if (xfer) begin
            count <= len_full;
            if ({1'b0, len_full} > CAPACITY) load_error <= 1'b1;
          end
        end
        ST_DATA_HI: begin
          if (xfer) begin
            byte_hi <= rx_data;
            csum    <= csum ^ rx_data;
          end
        end
        // pc/instruction_in are loaded here so they are stable for the whole WRITE cycle and hold afterwards.
        ST_DATA_LO: begin
          if (xfer) begin
            csum           <= csum ^ rx_data;
            pc             <= addr;
            instruction_in <= WORD_BITS'({byte_hi, rx_data});
          end
        end
        ST_WRITE: begin
          addr         <= addr + 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
        ST_CSUM: begin
          if (xfer) begin
            load_done  <= (rx_data == csum);
            load_error <= (rx_data != csum);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
